game_state_controller: RTL and testbench

Sequences the PAC-MAN game: READY, PLAYING, DYING, GAME_OVER and WIN. It detects player/ghost collisions, runs the frightened (big-dot) timer, tracks lives and ghost-eating score, and issues a position-restart pulse to the character controllers. It replaces the constant game_state driven into the Renderer. It runs on the 25 MHz domain and advances only on the char-update tick strobe.

---
 rtl/game_state_controller_pkg.sv | 28 ++
 rtl/game_state_controller_collision.sv | 40 ++++
 rtl/game_state_controller.sv | 189 ++++++++++++++++++
 tb/tb_game_state_controller.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_state_controller_pkg.sv
// -----------------------------------------------------------------------------
// game_state_controller_pkg
// Shared types and widths for the PAC-MAN game state controller.
//   game_state_e : encoding seen by the Renderer (READY=0, PLAYING=1,
//                  DYING=2, GAME_OVER=3, WIN=4)
//   popcount4    : number of ghosts set in a 4-bit hit mask
// -----------------------------------------------------------------------------
package game_state_controller_pkg;

   localparam int unsigned NUM_GHOSTS = 4;
   localparam int unsigned STATE_W    = 3;
   localparam int unsigned LIVES_W    = 3;
   localparam int unsigned SCORE_W    = 16;
   localparam int unsigned DOTS_W     = 10;

   typedef enum logic [STATE_W-1:0] {
      GS_READY     = 3'd0,
      GS_PLAYING   = 3'd1,
      GS_DYING     = 3'd2,
      GS_GAME_OVER = 3'd3,
      GS_WIN       = 3'd4
   } game_state_e;

   function automatic logic [2:0] popcount4(input logic [NUM_GHOSTS-1:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/game_state_controller_collision.sv
// -----------------------------------------------------------------------------
// collision_detector
// Purely combinational player-vs-ghost proximity test for four ghosts.
//   player_x/player_y : player pixel position
//   ghost_x/ghost_y   : ghost k at [k*X_W +: X_W] / [k*Y_W +: Y_W]
//   hit               : hit[k] set when both axis distances are < HIT_DIST
// -----------------------------------------------------------------------------
module collision_detector
   import game_state_controller_pkg::*;
#(
   parameter int unsigned X_W      = 10,
   parameter int unsigned Y_W      = 9,
   parameter int unsigned HIT_DIST = 8
) (
   input  logic [X_W-1:0]            player_x,
   input  logic [Y_W-1:0]            player_y,
   input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
   input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
   output logic [NUM_GHOSTS-1:0]     hit
);

   for (genvar k = 0; k < NUM_GHOSTS; k++) begin : g_ghost
      logic [X_W-1:0] gx;
      logic [Y_W-1:0] gy;
      logic [X_W:0]   dx;
      logic [Y_W:0]   dy;

      assign gx = ghost_x[k*X_W +: X_W];
      assign gy = ghost_y[k*Y_W +: Y_W];

      // Unsigned absolute difference, one bit wider than the coordinate
      assign dx = (player_x >= gx) ? ((X_W+1)'(player_x) - (X_W+1)'(gx))
                                   : ((X_W+1)'(gx) - (X_W+1)'(player_x));
      assign dy = (player_y >= gy) ? ((Y_W+1)'(player_y) - (Y_W+1)'(gy))
                                   : ((Y_W+1)'(gy) - (Y_W+1)'(player_y));

      assign hit[k] = (dx < (X_W+1)'(HIT_DIST)) && (dy < (Y_W+1)'(HIT_DIST));
   end

endmodule

// File: rtl/game_state_controller.sv
// -----------------------------------------------------------------------------
// game_state_controller
// Sequences READY / PLAYING / DYING / GAME_OVER / WIN, tracks lives, the
// frightened timer and the ghost-eating score. All activity is qualified by
// the char-update tick; every output is registered.
//   clk, reset      : 25 MHz clock, synchronous active-high reset
//   tick            : one-cycle enable per char-update period
//   start           : start button level
//   player_*/ghost_*: character positions
//   dots_remaining  : uneaten dot count
//   big_dot_eaten   : one-cycle pulse, any clk cycle
//   game_state      : current state encoding
//   lives, score    : remaining lives, saturating ghost bonus
//   frightened      : ghosts vulnerable
//   ghost_eaten     : one-cycle pulse per eaten ghost
//   restart_pos     : one-cycle pulse, all characters return to spawn
// -----------------------------------------------------------------------------
module game_state_controller
   import game_state_controller_pkg::*;
#(
   parameter int unsigned X_W          = 10,
   parameter int unsigned Y_W          = 9,
   parameter int unsigned START_LIVES  = 3,
   parameter int unsigned READY_TICKS  = 200,
   parameter int unsigned DYING_TICKS  = 150,
   parameter int unsigned FRIGHT_TICKS = 600,
   parameter int unsigned HIT_DIST     = 8,
   parameter int unsigned GHOST_PTS    = 200
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tick,
   input  logic                      start,
   input  logic [X_W-1:0]            player_x,
   input  logic [Y_W-1:0]            player_y,
   input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
   input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
   input  logic [DOTS_W-1:0]         dots_remaining,
   input  logic                      big_dot_eaten,
   output logic [STATE_W-1:0]        game_state,
   output logic [LIVES_W-1:0]        lives,
   output logic                      frightened,
   output logic [NUM_GHOSTS-1:0]     ghost_eaten,
   output logic                      restart_pos,
   output logic [SCORE_W-1:0]        score
);

   localparam int unsigned PHASE_MAX = (READY_TICKS > DYING_TICKS) ? READY_TICKS : DYING_TICKS;
   localparam int unsigned TMR_W     = $clog2(PHASE_MAX + 1);
   localparam int unsigned FT_W      = $clog2(FRIGHT_TICKS + 1);
   localparam int unsigned SUM_W     = SCORE_W + 2;

   game_state_e             state_q;
   logic [TMR_W-1:0]        timer_q;
   logic [FT_W-1:0]         fright_tmr_q;
   logic                    fright_q;
   logic                    pending_q;
   logic [LIVES_W-1:0]      lives_q;
   logic [SCORE_W-1:0]      score_q;
   logic [NUM_GHOSTS-1:0]   ghost_eaten_q;
   logic                    restart_q;

   logic [NUM_GHOSTS-1:0]   hit_c;
   logic                    big_dot_c;
   logic [SUM_W-1:0]        score_sum_c;
   logic [SCORE_W-1:0]      score_sat_c;

   collision_detector #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .HIT_DIST (HIT_DIST)
   ) u_collision (
      .player_x (player_x),
      .player_y (player_y),
      .ghost_x  (ghost_x),
      .ghost_y  (ghost_y),
      .hit      (hit_c)
   );

   // A big dot arriving on the tick cycle itself is consumed by that tick
   assign big_dot_c = pending_q | big_dot_eaten;

   // Ghost bonus with saturation at all-ones
   assign score_sum_c = SUM_W'(score_q) + SUM_W'(GHOST_PTS * 32'(popcount4(hit_c)));
   assign score_sat_c = (|score_sum_c[SUM_W-1:SCORE_W]) ? '1 : score_sum_c[SCORE_W-1:0];

   // Game sequencing, timers, lives and score
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= GS_READY;
         timer_q       <= '0;
         fright_tmr_q  <= '0;
         fright_q      <= 1'b0;
         pending_q     <= 1'b0;
         lives_q       <= LIVES_W'(START_LIVES);
         score_q       <= '0;
         ghost_eaten_q <= '0;
         restart_q     <= 1'b1;
      end else begin
         ghost_eaten_q <= '0;
         restart_q     <= 1'b0;
         if (big_dot_eaten) pending_q <= 1'b1;

         if (tick) begin
            pending_q <= 1'b0;
            case (state_q)
               GS_READY: begin
                  if (timer_q == TMR_W'(READY_TICKS - 1)) begin
                     state_q <= GS_PLAYING;
                     timer_q <= '0;
                  end else begin
                     timer_q <= timer_q + TMR_W'(1);
                  end
               end

               GS_PLAYING: begin
                  if (dots_remaining == '0) begin
                     state_q      <= GS_WIN;
                     fright_q     <= 1'b0;
                     fright_tmr_q <= '0;
                  end else if ((|hit_c) && !fright_q) begin
                     state_q      <= GS_DYING;
                     timer_q      <= '0;
                     lives_q      <= (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                     fright_q     <= 1'b0;
                     fright_tmr_q <= '0;
                  end else begin
                     if (fright_q) begin
                        ghost_eaten_q <= hit_c;
                        score_q       <= score_sat_c;
                     end
                     // Reload wins over countdown; the tick that reaches 0 clears fright
                     if (big_dot_c) begin
                        fright_q     <= 1'b1;
                        fright_tmr_q <= FT_W'(FRIGHT_TICKS);
                     end else if (fright_q) begin
                        if (fright_tmr_q <= FT_W'(1)) begin
                           fright_q     <= 1'b0;
                           fright_tmr_q <= '0;
                        end else begin
                           fright_tmr_q <= fright_tmr_q - FT_W'(1);
                        end
                     end
                  end
               end

               GS_DYING: begin
                  fright_q     <= 1'b0;
                  fright_tmr_q <= '0;
                  if (timer_q == TMR_W'(DYING_TICKS - 1)) begin
                     timer_q <= '0;
                     if (lives_q == '0) begin
                        state_q <= GS_GAME_OVER;
                     end else begin
                        state_q   <= GS_READY;
                        restart_q <= 1'b1;
                     end
                  end else begin
                     timer_q <= timer_q + TMR_W'(1);
                  end
               end

               GS_GAME_OVER, GS_WIN: begin
                  if (start) begin
                     state_q   <= GS_READY;
                     timer_q   <= '0;
                     lives_q   <= LIVES_W'(START_LIVES);
                     score_q   <= '0;
                     restart_q <= 1'b1;
                  end
               end

               default: begin
                  state_q <= GS_READY;
                  timer_q <= '0;
               end
            endcase
         end
      end
   end

   assign game_state  = state_q;
   assign lives       = lives_q;
   assign frightened  = fright_q;
   assign ghost_eaten = ghost_eaten_q;
   assign restart_pos = restart_q;
   assign score       = score_q;

endmodule

// File: tb/tb_game_state_controller.sv
// -----------------------------------------------------------------------------
// tb_game_state_controller
// Scenario tasks plus a randomized run, all compared against a tick-level
// behavioural model of the game rules.
// -----------------------------------------------------------------------------
module tb_game_state_controller;

   localparam int READY_T  = 200;
   localparam int DYING_T  = 150;
   localparam int FRIGHT_T = 600;
   localparam int HIT      = 8;
   localparam int PTS      = 200;
   localparam int LIVES0   = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  player_x = 10'd100;
   logic [8:0]  player_y = 9'd100;
   logic [39:0] ghost_x = '0;
   logic [35:0] ghost_y = '0;
   logic [9:0]  dots_remaining = 10'd50;
   logic        big_dot_eaten = 1'b0;
   logic [2:0]  game_state;
   logic [2:0]  lives;
   logic        frightened;
   logic [3:0]  ghost_eaten;
   logic        restart_pos;
   logic [15:0] score;

   int checks = 0;
   int failures = 0;

   // model state
   int       m_state, m_lives, m_score, m_phase_ticks, m_fright_left;
   bit       m_fright, m_pending, m_restart;
   logic [3:0] m_eaten;

   wire [27:0] dut_vec = {game_state, lives, frightened, ghost_eaten, restart_pos, score};

   game_state_controller dut (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick),
      .start          (start),
      .player_x       (player_x),
      .player_y       (player_y),
      .ghost_x        (ghost_x),
      .ghost_y        (ghost_y),
      .dots_remaining (dots_remaining),
      .big_dot_eaten  (big_dot_eaten),
      .game_state     (game_state),
      .lives          (lives),
      .frightened     (frightened),
      .ghost_eaten    (ghost_eaten),
      .restart_pos    (restart_pos),
      .score          (score)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [27:0] exp_vec();
      return {3'(m_state), 3'(m_lives), m_fright, m_eaten, m_restart, 16'(m_score)};
   endfunction

   function automatic int absdiff(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   task automatic model_reset();
      m_state = 0; m_lives = LIVES0; m_score = 0; m_phase_ticks = 0;
      m_fright_left = 0; m_fright = 0; m_pending = 0; m_restart = 1; m_eaten = 4'd0;
   endtask

   // Game rules applied once per tick using the inputs currently driven
   task automatic model_tick();
      logic [3:0] touching;
      int n;
      touching = 4'd0;
      for (int k = 0; k < 4; k++)
         if (absdiff(int'(player_x), int'(ghost_x[k*10 +: 10])) < HIT &&
             absdiff(int'(player_y), int'(ghost_y[k*9 +: 9])) < HIT)
            touching[k] = 1'b1;
      n = $countones(touching);
      m_eaten = 4'd0;
      m_restart = 0;
      case (m_state)
         0: begin
            m_phase_ticks++;
            if (m_phase_ticks == READY_T) begin m_state = 1; m_phase_ticks = 0; end
         end
         1: begin
            if (dots_remaining == 0) begin
               m_state = 4; m_fright = 0; m_fright_left = 0;
            end else if (n > 0 && !m_fright) begin
               m_state = 2; m_phase_ticks = 0; m_fright = 0; m_fright_left = 0;
               if (m_lives > 0) m_lives--;
            end else begin
               if (m_fright) begin
                  m_eaten = touching;
                  m_score = m_score + PTS * n;
                  if (m_score > 65535) m_score = 65535;
               end
               if (m_pending) begin
                  m_fright = 1; m_fright_left = FRIGHT_T;
               end else if (m_fright) begin
                  m_fright_left--;
                  if (m_fright_left == 0) m_fright = 0;
               end
            end
         end
         2: begin
            m_fright = 0; m_fright_left = 0;
            m_phase_ticks++;
            if (m_phase_ticks == DYING_T) begin
               m_phase_ticks = 0;
               if (m_lives == 0) m_state = 3;
               else begin m_state = 0; m_restart = 1; end
            end
         end
         default: begin
            if (start) begin
               m_state = 0; m_phase_ticks = 0; m_lives = LIVES0; m_score = 0; m_restart = 1;
            end
         end
      endcase
      m_pending = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   // Optional big-dot pulse on an idle cycle, idle gap, then one tick
   task automatic step(input int gap, input bit bd);
      if (bd) begin
         big_dot_eaten = 1'b1;
         @(posedge clk); #1;
         big_dot_eaten = 1'b0;
         m_pending = 1;
      end
      repeat (gap) begin @(posedge clk); #1; end
      model_tick();
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) step($urandom_range(1, 3), 1'b0);
   endtask

   task automatic set_far();
      ghost_x = {10'd700, 10'd600, 10'd500, 10'd400};
      ghost_y = {4{9'd450}};
   endtask

   task automatic set_ghost(input int k, input int x, input int y);
      ghost_x[k*10 +: 10] = 10'(x);
      ghost_y[k*9 +: 9]   = 9'(y);
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      m_restart = 0;
      m_eaten = 4'd0;
   endtask

   task automatic test_reset();
      set_far();
      do_reset();
      checks++;
      if ({game_state, lives, frightened, ghost_eaten, score} !== {3'd0, 3'd3, 1'b0, 4'd0, 16'd0}) begin
         failures++;
         $display("FAIL reset_values: got state=%0d lives=%0d fr=%0d ge=%b score=%0d", game_state, lives, frightened, ghost_eaten, score);
      end
      checks++;
      if (restart_pos !== 1'b1) begin failures++; $display("FAIL reset_restart_pulse: got %b expected 1", restart_pos); end
      idle_cycle();
      checks++;
      if (restart_pos !== 1'b0) begin failures++; $display("FAIL reset_restart_clear: got %b expected 0", restart_pos); end
      run_ticks(READY_T - 1);
      checks++;
      if (game_state !== 3'd0) begin failures++; $display("FAIL ready_hold: state=%0d expected 0", game_state); end
      run_ticks(1);
      checks++;
      if (game_state !== 3'd1 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL ready_to_playing: dut=%h model=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_death();
      set_far();
      set_ghost(2, 105, 94);
      step(2, 1'b0);
      checks++;
      if (game_state !== 3'd2 || lives !== 3'd2 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL death_hit: state=%0d lives=%0d model=%h", game_state, lives, exp_vec());
      end
      set_far();
      run_ticks(DYING_T);
      checks++;
      if (game_state !== 3'd0 || restart_pos !== 1'b1 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL dying_to_ready: state=%0d restart=%b model=%h", game_state, restart_pos, exp_vec());
      end
      idle_cycle();
      checks++;
      if (restart_pos !== 1'b0) begin failures++; $display("FAIL restart_one_cycle: got %b expected 0", restart_pos); end
      run_ticks(READY_T);
      set_ghost(2, 108, 100);
      set_ghost(1, 100, 92);
      step(2, 1'b0);
      checks++;
      if (game_state !== 3'd1 || lives !== 3'd2 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL distance8_no_hit: state=%0d lives=%0d model=%h", game_state, lives, exp_vec());
      end
      set_far();
   endtask

   task automatic test_fright();
      bit exp_fr;
      set_far();
      step(2, 1'b1);
      checks++;
      if (frightened !== 1'b1) begin failures++; $display("FAIL fright_set: got %b expected 1", frightened); end
      set_ghost(0, 100, 100);
      set_ghost(3, 103, 97);
      step(2, 1'b0);
      checks++;
      if (ghost_eaten !== 4'b1001 || score !== 16'd400 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL eat_two: ge=%b score=%0d model=%h", ghost_eaten, score, exp_vec());
      end
      idle_cycle();
      checks++;
      if (ghost_eaten !== 4'b0000) begin failures++; $display("FAIL eaten_one_cycle: got %b expected 0000", ghost_eaten); end
      set_far();
      for (int i = 2; i <= FRIGHT_T; i++) begin
         step($urandom_range(1, 2), 1'b0);
         exp_fr = (i < FRIGHT_T);
         checks++;
         if (frightened !== exp_fr || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL fright_expire t=%0d: fr=%b expected %b model=%h", i, frightened, exp_fr, exp_vec());
         end
      end
      step(1, 1'b1);
      for (int i = 1; i <= 900; i++) begin
         step($urandom_range(1, 2), i == 300);
         exp_fr = (i < 900);
         checks++;
         if (frightened !== exp_fr || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL fright_extend t=%0d: fr=%b expected %b model=%h", i, frightened, exp_fr, exp_vec());
         end
      end
   endtask

   task automatic test_game_over();
      set_ghost(1, 98, 103);
      step(1, 1'b0);
      set_far();
      run_ticks(DYING_T + READY_T);
      set_ghost(1, 98, 103);
      step(1, 1'b0);
      checks++;
      if (game_state !== 3'd2 || lives !== 3'd0) begin
         failures++; $display("FAIL last_life: state=%0d lives=%0d expected 2/0", game_state, lives);
      end
      set_far();
      run_ticks(DYING_T);
      checks++;
      if (game_state !== 3'd3 || lives !== 3'd0 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL game_over: dut=%h model=%h", dut_vec, exp_vec());
      end
      start = 1'b1;
      repeat (10) idle_cycle();
      checks++;
      if (game_state !== 3'd3) begin failures++; $display("FAIL start_without_tick: state=%0d expected 3", game_state); end
      step(1, 1'b0);
      start = 1'b0;
      checks++;
      if (game_state !== 3'd0 || lives !== 3'd3 || score !== 16'd0 || restart_pos !== 1'b1 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL restart_game: dut=%h model=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_win_priority();
      run_ticks(READY_T);
      dots_remaining = 10'd0;
      set_ghost(0, 100, 100);
      step(1, 1'b0);
      checks++;
      if (game_state !== 3'd4 || lives !== 3'd3 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL win_priority: state=%0d lives=%0d model=%h", game_state, lives, exp_vec());
      end
      set_far();
      dots_remaining = 10'd50;
      start = 1'b1;
      step(1, 1'b0);
      start = 1'b0;
      checks++;
      if (game_state !== 3'd0 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL win_restart: dut=%h model=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_reset_midgame();
      run_ticks(READY_T);
      set_ghost(0, 100, 100);
      step(1, 1'b0);
      set_far();
      run_ticks(20);
      do_reset();
      checks++;
      if (game_state !== 3'd0 || frightened !== 1'b0 || lives !== 3'd3) begin
         failures++; $display("FAIL reset_in_dying: state=%0d fr=%b lives=%0d", game_state, frightened, lives);
      end
      run_ticks(READY_T);
      step(1, 1'b1);
      run_ticks(10);
      do_reset();
      checks++;
      if (game_state !== 3'd0 || frightened !== 1'b0 || lives !== 3'd3 || score !== 16'd0) begin
         failures++; $display("FAIL reset_in_fright: state=%0d fr=%b lives=%0d score=%0d", game_state, frightened, lives, score);
      end
   endtask

   task automatic test_saturation();
      run_ticks(READY_T);
      step(1, 1'b1);
      for (int k = 0; k < 4; k++) set_ghost(k, 100, 100);
      run_ticks(81);
      checks++;
      if (score !== 16'd64800) begin failures++; $display("FAIL score_accumulate: got %0d expected 64800", score); end
      set_ghost(3, 600, 450);
      step(1, 1'b0);
      checks++;
      if (score !== 16'd65400) begin failures++; $display("FAIL score_65400: got %0d expected 65400", score); end
      set_ghost(2, 600, 400);
      step(1, 1'b0);
      checks++;
      if (score !== 16'hFFFF || ghost_eaten !== 4'b0011 || dut_vec !== exp_vec()) begin
         failures++; $display("FAIL score_saturate: score=%0d ge=%b model=%h", score, ghost_eaten, exp_vec());
      end
      step(1, 1'b0);
      checks++;
      if (score !== 16'hFFFF) begin failures++; $display("FAIL score_hold_sat: got %0d expected 65535", score); end
      set_far();
   endtask

   task automatic test_random();
      int px, py;
      for (int i = 0; i < 1500; i++) begin
         px = $urandom_range(20, 900);
         py = $urandom_range(20, 480);
         player_x = 10'(px);
         player_y = 9'(py);
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 9) == 0)
               set_ghost(k, px + $urandom_range(0, 20) - 10, py + $urandom_range(0, 20) - 10);
            else
               set_ghost(k, (px + 300 + 40 * k) % 1000, (py + 200) % 500);
         end
         dots_remaining = ($urandom_range(0, 149) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
         start = ($urandom_range(0, 19) == 0);
         step($urandom_range(1, 3), $urandom_range(0, 14) == 0);
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++; $display("FAIL random_tick %0d: dut=%h model=%h", i, dut_vec, exp_vec());
         end
      end
      start = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_death();
      test_fright();
      test_game_over();
      test_win_priority();
      test_reset_midgame();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
